// File: rtl/glue_irq_pkg.sv
// Shared types and constants for the interrupt glue: FSM states,
// CPU interrupt levels and the priority encoder for ipl.
package glue_irq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DECODE   = 2'd1,
        WAIT_VEC = 2'd2,
        ACK      = 2'd3
    } irq_state_t;

    localparam logic [2:0] LVL_HBL  = 3'd2;
    localparam logic [2:0] LVL_VBL  = 3'd4;
    localparam logic [2:0] LVL_MFP  = 3'd6;
    localparam logic [2:0] LVL_NONE = 3'd0;

    // MFP outranks VBL, which outranks HBL.
    function automatic logic [2:0] encode_ipl(input logic mfp, input logic vbl, input logic hbl);
        if (mfp)
            return LVL_MFP;
        else if (vbl)
            return LVL_VBL;
        else if (hbl)
            return LVL_HBL;
        else
            return LVL_NONE;
    endfunction

endpackage

// File: rtl/glue_edge_det.sv
// Rising-edge detector: one registered copy of the input, pulse while the
// live input is high and the registered copy is still low.
module glue_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);

    logic sig_q;

    // Cleared on reset so an input already high at release counts as an edge.
    always_ff @(posedge clk) begin
        if (reset)
            sig_q <= 1'b0;
        else
            sig_q <= sig_in;
    end

    assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/glue_irq.sv
// Interrupt glue between MFP / video blanking and the CPU: latches blanking
// events, encodes ipl, and runs the interrupt-acknowledge handshake.
module glue_irq
    import glue_irq_pkg::*;
#(
    parameter int IACK_DELAY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mfp_irq,
    input  logic       hbl_in,
    input  logic       vbl_in,
    input  logic       cpu_iack,
    input  logic [2:0] cpu_iack_level,
    output logic [2:0] ipl,
    output logic       mfp_iack,
    output logic       avec,
    output logic       dtack,
    output logic       spurious
);

    localparam logic [3:0] CNT_LOAD = 4'(IACK_DELAY - 1);

    irq_state_t state, state_nxt;
    logic [2:0] level_q, level_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       mfp_iack_nxt, avec_nxt, dtack_nxt, spurious_nxt;
    logic       hbl_rise, vbl_rise;
    logic       hbl_pend, vbl_pend;
    logic       hbl_clr, vbl_clr;
    logic       hbl_pend_nxt, vbl_pend_nxt;

    glue_edge_det u_hbl_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_in (hbl_in),
        .rise   (hbl_rise)
    );

    glue_edge_det u_vbl_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_in (vbl_in),
        .rise   (vbl_rise)
    );

    // A fresh edge in the same clock as the acknowledge clear keeps the bit set.
    assign hbl_pend_nxt = hbl_rise | (hbl_pend & ~hbl_clr);
    assign vbl_pend_nxt = vbl_rise | (vbl_pend & ~vbl_clr);

    always_comb begin
        state_nxt    = state;
        level_nxt    = level_q;
        cnt_nxt      = cnt;
        mfp_iack_nxt = mfp_iack;
        avec_nxt     = avec;
        dtack_nxt    = dtack;
        spurious_nxt = spurious;
        hbl_clr      = 1'b0;
        vbl_clr      = 1'b0;

        case (state)
            IDLE: begin
                if (cpu_iack) begin
                    state_nxt = DECODE;
                    level_nxt = cpu_iack_level;
                end
            end

            DECODE: begin
                if (!cpu_iack) begin
                    state_nxt    = IDLE;
                    mfp_iack_nxt = 1'b0;
                    avec_nxt     = 1'b0;
                    dtack_nxt    = 1'b0;
                    spurious_nxt = 1'b0;
                end else if (level_q == LVL_MFP && mfp_irq) begin
                    mfp_iack_nxt = 1'b1;
                    cnt_nxt      = CNT_LOAD;
                    state_nxt    = WAIT_VEC;
                end else if (level_q == LVL_VBL && vbl_pend) begin
                    vbl_clr   = 1'b1;
                    avec_nxt  = 1'b1;
                    state_nxt = ACK;
                end else if (level_q == LVL_HBL && hbl_pend) begin
                    hbl_clr   = 1'b1;
                    avec_nxt  = 1'b1;
                    state_nxt = ACK;
                end else begin
                    spurious_nxt = 1'b1;
                    state_nxt    = ACK;
                end
            end

            // mfp_irq is deliberately ignored here: once the MFP is strobed
            // the vector cycle runs to completion.
            WAIT_VEC: begin
                if (!cpu_iack) begin
                    state_nxt    = IDLE;
                    mfp_iack_nxt = 1'b0;
                    avec_nxt     = 1'b0;
                    dtack_nxt    = 1'b0;
                    spurious_nxt = 1'b0;
                    cnt_nxt      = 4'd0;
                end else if (cnt == 4'd0) begin
                    dtack_nxt = 1'b1;
                    state_nxt = ACK;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end

            ACK: begin
                if (!cpu_iack) begin
                    state_nxt    = IDLE;
                    mfp_iack_nxt = 1'b0;
                    avec_nxt     = 1'b0;
                    dtack_nxt    = 1'b0;
                    spurious_nxt = 1'b0;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            level_q  <= 3'd0;
            cnt      <= 4'd0;
            hbl_pend <= 1'b0;
            vbl_pend <= 1'b0;
            ipl      <= LVL_NONE;
            mfp_iack <= 1'b0;
            avec     <= 1'b0;
            dtack    <= 1'b0;
            spurious <= 1'b0;
        end else begin
            state    <= state_nxt;
            level_q  <= level_nxt;
            cnt      <= cnt_nxt;
            hbl_pend <= hbl_pend_nxt;
            vbl_pend <= vbl_pend_nxt;
            ipl      <= encode_ipl(mfp_irq, vbl_pend_nxt, hbl_pend_nxt);
            mfp_iack <= mfp_iack_nxt;
            avec     <= avec_nxt;
            dtack    <= dtack_nxt;
            spurious <= spurious_nxt;
        end
    end

endmodule
